// File: rtl/rv32i_memoryaccess_pkg.sv
// Shared definitions for the RV32I memory-access stage: one-hot opcode
// indices, funct3 access codes, FSM state encoding and the access-size
// decode used by both the lane aligner and the misalignment check.
package rv32i_memoryaccess_pkg;

    // One-hot opcode bit indices as produced by the decode stage.
    localparam int OPCODE_WIDTH  = 11;
    localparam int OPCODE_RTYPE  = 0;
    localparam int OPCODE_ITYPE  = 1;
    localparam int OPCODE_LOAD   = 2;
    localparam int OPCODE_STORE  = 3;
    localparam int OPCODE_BRANCH = 4;
    localparam int OPCODE_JAL    = 5;
    localparam int OPCODE_JALR   = 6;
    localparam int OPCODE_LUI    = 7;
    localparam int OPCODE_AUIPC  = 8;
    localparam int OPCODE_SYSTEM = 9;
    localparam int OPCODE_FENCE  = 10;

    // funct3 encodings of the load/store instructions.
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ABORT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Access width of a load or store; unsupported funct3 values act as a word.
    function automatic size_t access_size(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            case (funct3)
                FUNCT3_SB: return SZ_BYTE;
                FUNCT3_SH: return SZ_HALF;
                FUNCT3_SW: return SZ_WORD;
                default:   return SZ_WORD;
            endcase
        end
        case (funct3)
            FUNCT3_LB, FUNCT3_LBU: return SZ_BYTE;
            FUNCT3_LH, FUNCT3_LHU: return SZ_HALF;
            FUNCT3_LW:             return SZ_WORD;
            default:               return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational lane logic of the memory-access stage: byte selects and
// replicated store data for the bus, and lane extraction plus sign/zero
// extension of returned load data.
module rv32i_lsu_align
    import rv32i_memoryaccess_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  sel,
    output logic [31:0] wb_wdata,
    output logic [31:0] load_ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    assign lane_b = load_raw[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
    // funct3[2] marks the unsigned load variants (LBU/LHU).
    assign sext   = ~funct3[2];

    // Select lanes and extend according to the access width.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        sel      = 4'b1111;
        wb_wdata = store_data;
        load_ext = load_raw;
        unique case (access_size(is_store, funct3))
            SZ_BYTE: begin
                sel      = 4'b0001 << addr_lo;
                wb_wdata = {4{store_data[7:0]}};
                load_ext = {{24{sext & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                sel      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wb_wdata = {2{store_data[15:0]}};
                load_ext = {{16{sext & lane_h[15]}}, lane_h};
            end
            default: begin
                sel      = 4'b1111;
                wb_wdata = store_data;
                load_ext = load_raw;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_memoryaccess.sv
// Memory-access stage of the multi-cycle RV32I core. Issues one
// Wishbone-style data transaction per LOAD/STORE, completes other opcodes
// without bus activity, and produces the extended load result consumed by
// writeback. All outputs are registered.
// Optional build macro MISALIGNED_TRAP_EN: misaligned half/word accesses
// complete immediately with o_misaligned instead of touching the bus.
module rv32i_memoryaccess
    import rv32i_memoryaccess_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
)
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_memoryaccess_en,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic [2:0]              i_funct3,
    input  logic [31:0]             i_address,
    input  logic [31:0]             i_rs2_data,
    output logic [31:0]             o_load_data,
    output logic                    o_done,
    output logic                    o_busy,
    output logic                    o_bus_err,
    output logic                    o_misaligned,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [31:0]             o_wb_addr,
    output logic [31:0]             o_wb_data,
    output logic [3:0]              o_wb_sel,
    input  logic                    i_wb_stall,
    input  logic                    i_wb_ack,
    input  logic [31:0]             i_wb_data
);

    // Counter only has to reach ACK_TIMEOUT-1.
    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

    state_t             state_q, state_d;
    logic               store_q, store_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         lo_q, lo_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [31:0]        load_q, load_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               mis_q, mis_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         sel_q, sel_d;

    logic               is_store_in;
    logic               is_mem;
    logic               trap_hit;
    logic               tmo_hit;
    logic               al_store;
    logic [2:0]         al_f3;
    logic [1:0]         al_lo;
    logic [3:0]         al_sel;
    logic [31:0]        al_wdata;
    logic [31:0]        al_load;
    logic               unused_opcode;

    assign is_store_in   = i_opcode[OPCODE_STORE];
    assign is_mem        = i_opcode[OPCODE_LOAD] | i_opcode[OPCODE_STORE];
    // Only the LOAD/STORE bits matter here; the rest of the one-hot vector is don't-care.
    assign unused_opcode = ^i_opcode;

    // In IDLE the aligner sees the incoming request; afterwards the latched one,
    // so the load lane is extracted with the address of the access in flight.
    assign al_store = (state_q == ST_IDLE) ? is_store_in     : store_q;
    assign al_f3    = (state_q == ST_IDLE) ? i_funct3        : f3_q;
    assign al_lo    = (state_q == ST_IDLE) ? i_address[1:0]  : lo_q;

    rv32i_lsu_align u_align (
        .is_store   (al_store),
        .funct3     (al_f3),
        .addr_lo    (al_lo),
        .store_data (i_rs2_data),
        .load_raw   (i_wb_data),
        .sel        (al_sel),
        .wb_wdata   (al_wdata),
        .load_ext   (al_load)
    );

`ifdef MISALIGNED_TRAP_EN
    // Flag half accesses on odd addresses and word accesses off a word boundary.
    always_comb begin
        trap_hit = 1'b0;
        unique case (access_size(is_store_in, i_funct3))
            SZ_HALF: trap_hit = i_address[0];
            SZ_WORD: trap_hit = |i_address[1:0];
            default: trap_hit = 1'b0;
        endcase
    end
`else
    assign trap_hit = 1'b0;
`endif

    // A timeout of zero disables the watchdog entirely.
    assign tmo_hit = (ACK_TIMEOUT != 0) && (32'(tmo_q) == 32'(ACK_TIMEOUT - 1));

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_d = state_q;
        store_d = store_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        tmo_d   = tmo_q;
        load_d  = load_q;
        busy_d  = busy_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mis_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_memoryaccess_en) begin
                    busy_d = 1'b1;
                    if (!is_mem) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (trap_hit) begin
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        store_d = is_store_in;
                        f3_d    = i_funct3;
                        lo_d    = i_address[1:0];
                        tmo_d   = '0;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = is_store_in;
                        addr_d  = {i_address[31:2], 2'b00};
                        wdata_d = is_store_in ? al_wdata : 32'd0;
                        sel_d   = al_sel;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                if (i_wb_ack) begin
                    // Ack takes priority over a coincident timeout.
                    cyc_d  = 1'b0;
                    stb_d  = 1'b0;
                    we_d   = 1'b0;
                    sel_d  = 4'b0000;
                    done_d = 1'b1;
                    if (!store_q) begin
                        load_d = al_load;
                    end
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'b0000;
                    state_d = ST_ABORT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (state_q == ST_REQ && !i_wb_stall) begin
                        stb_d   = 1'b0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_ABORT: begin
                done_d = 1'b1;
                err_d  = 1'b1;
                if (!store_q) begin
                    load_d = 32'd0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'd0;
            lo_q    <= 2'd0;
            tmo_q   <= '0;
            load_q  <= 32'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            sel_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            tmo_q   <= tmo_d;
            load_q  <= load_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
        end
    end

    assign o_load_data  = load_q;
    assign o_done       = done_q;
    assign o_busy       = busy_q;
    assign o_bus_err    = err_q;
    assign o_misaligned = mis_q;
    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = we_q;
    assign o_wb_addr    = addr_q;
    assign o_wb_data    = wdata_q;
    assign o_wb_sel     = sel_q;

endmodule
